dual_port_ram_pipe: RTL and testbench
=====================================

// Module: dual_port_ram_pipe
// PURPOSE
//   Parametrised simple dual-port RAM: one write port and one read port on a single clock.
//   Adds per-byte write enables, a selectable 1- or 2-cycle registered read pipeline with a
//   valid strobe, a selectable read-during-write mode and a same-address collision flag.
//   General scratch/buffer memory for datapath blocks; drives a tri-statable output bus.
// PARAMETERS
//   ADDR_SIZE     4    address width in bits
//   DATA_SIZE     32   word width; must be a multiple of 8 (BE_WIDTH = DATA_SIZE/8)
//   DEPTH         16   number of words; DEPTH <= 2**ADDR_SIZE
//   READ_LATENCY  1    cycles from accepted read to rd_valid; legal values 1 or 2
//   RDW_MODE      0    same-address read during write: 0 = old data, 1 = new data (per byte)
// PORTS
//   clk         in   1           rising-edge clock
//   rst         in   1           asynchronous, active-high reset
//   cs          in   1           chip select; gates both read and write acceptance
//   we          in   1           write request
//   be          in   BE_WIDTH    byte-lane write enables (bit i -> data_in[8i+7:8i])
//   wr_address  in   ADDR_SIZE   write address
//   data_in     in   DATA_SIZE   write data
//   re          in   1           read request
//   rd_address  in   ADDR_SIZE   read address
//   oe          in   1           output enable for data_out
//   data_out    out  DATA_SIZE   read data; high-Z when oe = 0
//   rd_valid    out  1           one-cycle pulse: data_out holds a newly completed read
//   collision   out  1           qualifies rd_valid: that read hit the address written same cycle
// BEHAVIOUR
//   - Reset (async assert, synchronous release): output data register = 0, rd_valid = 0,
//     collision = 0, all pipeline valid bits = 0. Memory array is NOT cleared.
//     While rst = 1 no write and no read is accepted.
//   - Write: at posedge with cs & we & !rst, lanes with be[i] = 1 update mem[wr_address];
//     other lanes keep their value. be = 0 is a legal no-op write.
//   - Read accept: at posedge N with cs & re & !rst, rd_address is sampled.
//     READ_LATENCY 1: result registered at edge N; rd_valid = 1 during cycle N..N+1.
//     READ_LATENCY 2: extra register stage; result and rd_valid appear one cycle later.
//     Back-to-back reads every cycle give one rd_valid per read, in order, no bubbles.
//   - Hold: with no completing read, the output data register keeps its last value;
//     rd_valid and collision are 0.
//   - data_out = oe ? output data register : all-Z. oe does not affect the pipeline;
//     cs is not required to drive data_out after the read was accepted.
//   - Collision: read and write accepted on the same edge, rd_address == wr_address,
//     be != 0. collision = 1 in the same cycle as that read's rd_valid.
//     RDW_MODE 0: returned word = memory contents before the write.
//     RDW_MODE 1: enabled lanes return data_in, disabled lanes return old contents.
//   - Out of range (address >= DEPTH): write ignored; read returns 0 with rd_valid = 1,
//     collision = 0.
//   - Reset mid-read: in-flight reads are discarded, with no rd_valid after release.
//     Contents already written stay intact.
//   - cs = 0: re and we ignored; reads in flight still complete.
// TESTING
//   1. Reset then write 0xDEADBEEF to addr 3 (be=4'hF), read addr 3, latency 1 ->
//      rd_valid 1 cycle after the read edge, data_out = 0xDEADBEEF.
//   2. mem[5] = 0x11223344; write 0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD.
//   3. Same-edge write 0xCAFEF00D be=4'hF / read addr 7 holding 0x0 ->
//      RDW_MODE 0: 0x00000000, collision = 1; RDW_MODE 1: 0xCAFEF00D, collision = 1.
//   4. READ_LATENCY 2: reads addr 0..15 on consecutive cycles -> 16 rd_valid pulses
//      starting 2 cycles after the first read, data in address order.
//   5. Issue a read, assert rst before completion -> no rd_valid, data_out = 0 (oe=1).
//      Earlier-written words still read back correctly after release.
//   6. oe = 0 during a completing read -> data_out = Z, rd_valid = 1.
//      Raise oe later -> held data driven. cs = 0 with re = 1 -> no rd_valid.

Source files
------------

// File: rtl/dual_port_ram_pipe_if.sv
// Bus interface for dual_port_ram_pipe: write port, read port, output enable and read results.
// The master side drives requests; the slave side is the RAM.
interface dual_port_ram_pipe_if #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 32
);
  localparam int unsigned BE_WIDTH = DATA_SIZE / 8;

  logic                 cs;
  logic                 we;
  logic [BE_WIDTH-1:0]  be;
  logic [ADDR_SIZE-1:0] wr_address;
  logic [DATA_SIZE-1:0] data_in;
  logic                 re;
  logic [ADDR_SIZE-1:0] rd_address;
  logic                 oe;
  logic [DATA_SIZE-1:0] data_out;
  logic                 rd_valid;
  logic                 collision;

  modport master (
    output cs, we, be, wr_address, data_in, re, rd_address, oe,
    input  data_out, rd_valid, collision
  );

  modport slave (
    input  cs, we, be, wr_address, data_in, re, rd_address, oe,
    output data_out, rd_valid, collision
  );
endinterface

// File: rtl/dual_port_ram_pipe.sv
// Simple dual-port RAM (one write port, one read port, one clock) with byte-lane write enables,
// a 1- or 2-stage registered read pipeline with valid strobe, selectable read-during-write
// behaviour, a same-address collision flag and a tri-statable data output.
module dual_port_ram_pipe #(
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = 0
) (
  input logic                   clk,
  input logic                   rst,
  dual_port_ram_pipe_if.slave   bus
);

  localparam int unsigned BE_WIDTH = DATA_SIZE / 8;
  // One extra bit so DEPTH == 2**ADDR_SIZE is representable.
  localparam logic [ADDR_SIZE:0] DepthLim = (ADDR_SIZE + 1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 wr_en;
  logic                 rd_accept;
  logic                 coll_hit;
  logic [DATA_SIZE-1:0] rd_word;

  // Results entering the final output register (directly or via the extra stage).
  logic                 fin_valid;
  logic                 fin_coll;
  logic [DATA_SIZE-1:0] fin_data;

  logic                 valid_q;
  logic                 coll_q;
  logic [DATA_SIZE-1:0] dout_q;

  // Request qualification: address range, acceptance and same-address collision.
  always_comb begin
    wr_in_range = ({1'b0, bus.wr_address} < DepthLim);
    rd_in_range = ({1'b0, bus.rd_address} < DepthLim);
    wr_en       = bus.cs & bus.we & wr_in_range;
    rd_accept   = bus.cs & bus.re;
    // wr_en already implies an in-range address, so equal addresses are in range too.
    coll_hit    = rd_accept & wr_en & (bus.rd_address == bus.wr_address) & (|bus.be);
  end

  // Read word: old contents, optionally overlaid with the colliding write's enabled lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_address];
      if (RDW_MODE == 1 && coll_hit) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (bus.be[i]) begin
            rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
          end
        end
      end
    end
  end

  // Memory array write; no reset on the array, writes blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.be[i]) begin
          mem[bus.wr_address][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 s1_valid_q;
    logic                 s1_coll_q;
    logic [DATA_SIZE-1:0] s1_data_q;

    // Extra read stage; reset drops any read in flight here.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_coll_q  <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_accept;
        s1_coll_q  <= coll_hit;
        if (rd_accept) begin
          s1_data_q <= rd_word;
        end
      end
    end

    // Feed the output register from the extra stage.
    always_comb begin
      fin_valid = s1_valid_q;
      fin_coll  = s1_coll_q;
      fin_data  = s1_data_q;
    end
  end else begin : g_lat1
    // Feed the output register straight from the accepted read.
    always_comb begin
      fin_valid = rd_accept;
      fin_coll  = coll_hit;
      fin_data  = rd_word;
    end
  end

  // Output register: loads only on a completing read, otherwise holds its last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      coll_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= fin_valid;
      coll_q  <= fin_valid & fin_coll;
      if (fin_valid) begin
        dout_q <= fin_data;
      end
    end
  end

  assign bus.data_out  = bus.oe ? dout_q : {DATA_SIZE{1'bz}};
  assign bus.rd_valid  = valid_q;
  assign bus.collision = coll_q;

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Directed bench for dual_port_ram_pipe. Three instances share one stimulus:
//   bus0: latency 1, old-data RDW, DEPTH 12 (addresses 12..15 out of range)
//   bus1: latency 2, old-data RDW, DEPTH 16
//   bus2: latency 1, new-data RDW, DEPTH 12
module tb_dual_port_ram_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  wr_address;
  logic [31:0] data_in;
  logic        re;
  logic [3:0]  rd_address;
  logic        oe;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dual_port_ram_pipe_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) bus0 ();
  dual_port_ram_pipe_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) bus1 ();
  dual_port_ram_pipe_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) bus2 ();

  assign bus0.cs = cs;  assign bus0.we = we;  assign bus0.be = be;
  assign bus0.wr_address = wr_address;  assign bus0.data_in = data_in;
  assign bus0.re = re;  assign bus0.rd_address = rd_address;  assign bus0.oe = oe;
  assign bus1.cs = cs;  assign bus1.we = we;  assign bus1.be = be;
  assign bus1.wr_address = wr_address;  assign bus1.data_in = data_in;
  assign bus1.re = re;  assign bus1.rd_address = rd_address;  assign bus1.oe = oe;
  assign bus2.cs = cs;  assign bus2.we = we;  assign bus2.be = be;
  assign bus2.wr_address = wr_address;  assign bus2.data_in = data_in;
  assign bus2.re = re;  assign bus2.rd_address = rd_address;  assign bus2.oe = oe;

  dual_port_ram_pipe #(
    .ADDR_SIZE(4), .DATA_SIZE(32), .DEPTH(12), .READ_LATENCY(1), .RDW_MODE(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  dual_port_ram_pipe #(
    .ADDR_SIZE(4), .DATA_SIZE(32), .DEPTH(16), .READ_LATENCY(2), .RDW_MODE(0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  dual_port_ram_pipe #(
    .ADDR_SIZE(4), .DATA_SIZE(32), .DEPTH(12), .READ_LATENCY(1), .RDW_MODE(1)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [31:0] pat(input int i);
    return 32'hB000_5500 | (32'(i) << 24) | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1'b1; we = 1'b1; wr_address = a; data_in = d; be = b;
    tick();
    we = 1'b0; be = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; we = 1'b0; be = 4'h0; wr_address = '0; data_in = '0;
    re = 1'b0; rd_address = '0; oe = 1'b1;
    tick(); tick();
    // A read requested while in reset must not be accepted.
    re = 1'b1; rd_address = 4'd1;
    tick(); tick();
    total++; if (bus0.rd_valid !== 1'b0) $display("FAIL reset_valid0: got %b want 0", bus0.rd_valid); else passed++;
    total++; if (bus0.collision !== 1'b0) $display("FAIL reset_coll0: got %b want 0", bus0.collision); else passed++;
    total++; if (bus0.data_out !== 32'h0) $display("FAIL reset_data0: got %h want 0", bus0.data_out); else passed++;
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL reset_valid1: got %b want 0", bus1.rd_valid); else passed++;
    total++; if (bus1.data_out !== 32'h0) $display("FAIL reset_data1: got %h want 0", bus1.data_out); else passed++;
    re = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    re = 1'b1; rd_address = 4'd3;
    tick();
    re = 1'b0;
    total++; if (bus0.rd_valid !== 1'b1) $display("FAIL wr_rd_valid0: got %b want 1", bus0.rd_valid); else passed++;
    total++; if (bus0.data_out !== 32'hDEADBEEF) $display("FAIL wr_rd_data0: got %h want deadbeef", bus0.data_out); else passed++;
    total++; if (bus0.collision !== 1'b0) $display("FAIL wr_rd_coll0: got %b want 0", bus0.collision); else passed++;
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL lat2_early: got %b want 0", bus1.rd_valid); else passed++;
    tick();
    total++; if (bus0.rd_valid !== 1'b0) $display("FAIL hold_valid0: got %b want 0", bus0.rd_valid); else passed++;
    total++; if (bus0.data_out !== 32'hDEADBEEF) $display("FAIL hold_data0: got %h want deadbeef", bus0.data_out); else passed++;
    total++; if (bus1.rd_valid !== 1'b1) $display("FAIL lat2_valid: got %b want 1", bus1.rd_valid); else passed++;
    total++; if (bus1.data_out !== 32'hDEADBEEF) $display("FAIL lat2_data: got %h want deadbeef", bus1.data_out); else passed++;
    tick();
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL lat2_single: got %b want 0", bus1.rd_valid); else passed++;
  endtask

  task automatic test_byte_enable();
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    wr(4'd5, 32'hFFFFFFFF, 4'h0);
    re = 1'b1; rd_address = 4'd5;
    tick();
    re = 1'b0;
    total++; if (bus0.data_out !== 32'h11BB33DD) $display("FAIL be_data0: got %h want 11bb33dd", bus0.data_out); else passed++;
    total++; if (bus2.data_out !== 32'h11BB33DD) $display("FAIL be_data2: got %h want 11bb33dd", bus2.data_out); else passed++;
    tick();
  endtask

  task automatic test_collision();
    wr(4'd7, 32'h0, 4'hF);
    cs = 1'b1; we = 1'b1; wr_address = 4'd7; data_in = 32'hCAFEF00D; be = 4'hF;
    re = 1'b1; rd_address = 4'd7;
    tick();
    we = 1'b0; re = 1'b0; be = 4'h0;
    total++; if (bus0.data_out !== 32'h0) $display("FAIL rdw_old_data: got %h want 0", bus0.data_out); else passed++;
    total++; if (bus0.collision !== 1'b1) $display("FAIL rdw_old_coll: got %b want 1", bus0.collision); else passed++;
    total++; if (bus2.data_out !== 32'hCAFEF00D) $display("FAIL rdw_new_data: got %h want cafef00d", bus2.data_out); else passed++;
    total++; if (bus2.collision !== 1'b1) $display("FAIL rdw_new_coll: got %b want 1", bus2.collision); else passed++;
    total++; if (bus1.collision !== 1'b0) $display("FAIL lat2_coll_early: got %b want 0", bus1.collision); else passed++;
    tick();
    total++; if (bus0.collision !== 1'b0) $display("FAIL coll_pulse: got %b want 0", bus0.collision); else passed++;
    total++; if (bus1.collision !== 1'b1) $display("FAIL lat2_coll: got %b want 1", bus1.collision); else passed++;
    // Partial-lane collision: only lanes 0..1 come from the write in new-data mode.
    cs = 1'b1; we = 1'b1; wr_address = 4'd7; data_in = 32'h12345678; be = 4'b0011;
    re = 1'b1; rd_address = 4'd7;
    tick();
    we = 1'b0; re = 1'b0; be = 4'h0;
    total++; if (bus0.data_out !== 32'hCAFEF00D) $display("FAIL part_old: got %h want cafef00d", bus0.data_out); else passed++;
    total++; if (bus2.data_out !== 32'hCAFE5678) $display("FAIL part_new: got %h want cafe5678", bus2.data_out); else passed++;
    // be == 0 on the same address is not a collision.
    cs = 1'b1; we = 1'b1; wr_address = 4'd7; data_in = 32'h0; be = 4'h0;
    re = 1'b1; rd_address = 4'd7;
    tick();
    we = 1'b0; re = 1'b0;
    total++; if (bus0.collision !== 1'b0) $display("FAIL be0_coll: got %b want 0", bus0.collision); else passed++;
    total++; if (bus2.data_out !== 32'hCAFE5678) $display("FAIL be0_data: got %h want cafe5678", bus2.data_out); else passed++;
    tick();
  endtask

  task automatic test_out_of_range();
    wr(4'd13, 32'h12345678, 4'hF);
    re = 1'b1; rd_address = 4'd13;
    tick();
    re = 1'b0;
    total++; if (bus0.rd_valid !== 1'b1) $display("FAIL oor_valid: got %b want 1", bus0.rd_valid); else passed++;
    total++; if (bus0.data_out !== 32'h0) $display("FAIL oor_data: got %h want 0", bus0.data_out); else passed++;
    tick();
    total++; if (bus1.data_out !== 32'h12345678) $display("FAIL inrange_data1: got %h want 12345678", bus1.data_out); else passed++;
    cs = 1'b1; we = 1'b1; wr_address = 4'd14; data_in = 32'h87654321; be = 4'hF;
    re = 1'b1; rd_address = 4'd14;
    tick();
    we = 1'b0; re = 1'b0; be = 4'h0;
    total++; if (bus0.collision !== 1'b0) $display("FAIL oor_coll: got %b want 0", bus0.collision); else passed++;
    total++; if (bus2.data_out !== 32'h0) $display("FAIL oor_rdw_data: got %h want 0", bus2.data_out); else passed++;
    total++; if (bus2.collision !== 1'b0) $display("FAIL oor_rdw_coll: got %b want 0", bus2.collision); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic       exp_v;
    logic [31:0] exp_d;
    for (int i = 0; i < 16; i++) wr(4'(i), pat(i), 4'hF);
    for (int k = 0; k < 18; k++) begin
      cs = 1'b1; re = (k < 16); rd_address = 4'(k);
      tick();
      if (bus1.rd_valid === 1'b1) pulses++;
      exp_v = (k >= 1 && k <= 16);
      total++; if (bus1.rd_valid !== exp_v) $display("FAIL b2b_valid1[%0d]: got %b want %b", k, bus1.rd_valid, exp_v); else passed++;
      if (exp_v) begin
        total++; if (bus1.data_out !== pat(k - 1)) $display("FAIL b2b_data1[%0d]: got %h want %h", k, bus1.data_out, pat(k - 1)); else passed++;
      end
      exp_v = (k < 16);
      total++; if (bus0.rd_valid !== exp_v) $display("FAIL b2b_valid0[%0d]: got %b want %b", k, bus0.rd_valid, exp_v); else passed++;
      if (exp_v) begin
        exp_d = (k < 12) ? pat(k) : 32'h0;
        total++; if (bus0.data_out !== exp_d) $display("FAIL b2b_data0[%0d]: got %h want %h", k, bus0.data_out, exp_d); else passed++;
      end
    end
    re = 1'b0;
    total++; if (pulses != 16) $display("FAIL b2b_pulses: got %0d want 16", pulses); else passed++;
  endtask

  task automatic test_reset_midread();
    re = 1'b1; rd_address = 4'd2;
    tick();
    re = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL midrst_valid1: got %b want 0", bus1.rd_valid); else passed++;
    total++; if (bus1.data_out !== 32'h0) $display("FAIL midrst_data1: got %h want 0", bus1.data_out); else passed++;
    total++; if (bus0.data_out !== 32'h0) $display("FAIL midrst_data0: got %h want 0", bus0.data_out); else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL post_rst_valid1a: got %b want 0", bus1.rd_valid); else passed++;
    tick();
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL post_rst_valid1b: got %b want 0", bus1.rd_valid); else passed++;
    re = 1'b1; rd_address = 4'd2;
    tick();
    re = 1'b0;
    total++; if (bus0.data_out !== pat(2)) $display("FAIL post_rst_mem: got %h want %h", bus0.data_out, pat(2)); else passed++;
    tick();
  endtask

  task automatic test_oe_cs();
    oe = 1'b0;
    re = 1'b1; rd_address = 4'd4;
    tick();
    re = 1'b0;
    total++; if (bus0.rd_valid !== 1'b1) $display("FAIL oe0_valid: got %b want 1", bus0.rd_valid); else passed++;
    // Released bus reads as Z; a two-state simulator resolves it to 0.
    total++; if (bus0.data_out !== 32'hzzzzzzzz && bus0.data_out !== 32'h0) $display("FAIL oe0_hiz: got %h want z", bus0.data_out); else passed++;
    oe = 1'b1;
    tick();
    total++; if (bus0.data_out !== pat(4)) $display("FAIL oe1_held: got %h want %h", bus0.data_out, pat(4)); else passed++;
    total++; if (bus0.rd_valid !== 1'b0) $display("FAIL oe1_valid: got %b want 0", bus0.rd_valid); else passed++;
    cs = 1'b0; re = 1'b1; rd_address = 4'd6; we = 1'b1; wr_address = 4'd4; data_in = 32'h0; be = 4'hF;
    tick();
    total++; if (bus0.rd_valid !== 1'b0) $display("FAIL cs0_valid0: got %b want 0", bus0.rd_valid); else passed++;
    re = 1'b0; we = 1'b0; be = 4'h0;
    tick();
    total++; if (bus1.rd_valid !== 1'b0) $display("FAIL cs0_valid1: got %b want 0", bus1.rd_valid); else passed++;
    cs = 1'b1; re = 1'b1; rd_address = 4'd4;
    tick();
    re = 1'b0;
    total++; if (bus0.data_out !== pat(4)) $display("FAIL cs0_nowrite: got %h want %h", bus0.data_out, pat(4)); else passed++;
    // Read in flight completes even after cs drops.
    cs = 1'b1; re = 1'b1; rd_address = 4'd9;
    tick();
    cs = 1'b0; re = 1'b0;
    tick();
    total++; if (bus1.rd_valid !== 1'b1) $display("FAIL inflight_valid1: got %b want 1", bus1.rd_valid); else passed++;
    total++; if (bus1.data_out !== pat(9)) $display("FAIL inflight_data1: got %h want %h", bus1.data_out, pat(9)); else passed++;
    cs = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_midread();
    test_oe_cs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
